// File: rtl/det_patgen_runner.sv
// BIST sequencer for a deterministic pattern generator and an SRAM under test.
// Steps the generator, registers its operations onto the SRAM port, compares
// read data against the generator's check word after the read latency, and
// holds pass/fail, a saturating error count and the first failing access.
module det_patgen_runner #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  start,
    output logic                  pg_en,
    output logic                  pg_rst,
    input  logic [ADDR_WIDTH-1:0] pg_addr,
    input  logic [DATA_WIDTH-1:0] pg_data,
    input  logic [DATA_WIDTH-1:0] pg_check,
    input  logic [MASK_WIDTH-1:0] pg_wmask,
    input  logic                  pg_we,
    input  logic                  pg_re,
    input  logic                  pg_done,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic [MASK_WIDTH-1:0] sram_wmask,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  proto_err,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual
);

    typedef enum logic [2:0] {
        StIdle,
        StPgRst,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic pg_rst_q;

    logic                  sram_ce_q;
    logic                  sram_we_q;
    logic [ADDR_WIDTH-1:0] sram_addr_q;
    logic [DATA_WIDTH-1:0] sram_din_q;
    logic [MASK_WIDTH-1:0] sram_wmask_q;

    // Check pipeline: stage 0 is loaded on the issue edge, the last stage is
    // compared against sram_dout on the following edge.
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [ADDR_WIDTH-1:0]   pipe_addr_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_chk_q  [READ_LATENCY];

    logic                  proto_err_q;
    logic [ERR_WIDTH-1:0]  err_count_q;
    logic                  fail_seen_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_expected_q;
    logic [DATA_WIDTH-1:0] fail_actual_q;

    logic issue;
    logic push;
    logic cmp_vld;
    logic mismatch;
    logic pend_after;

    // Operation issue and check-push qualifiers.
    always_comb begin
        issue    = (state_q == StRun) && !pg_done;
        // A simultaneous read+write is executed as a write, so no check is queued.
        push     = issue && pg_re && !pg_we;
        cmp_vld  = pipe_vld_q[READ_LATENCY-1];
        mismatch = cmp_vld && (sram_dout != pipe_chk_q[READ_LATENCY-1]);
    end

    // Any valid stage other than the one being consumed this edge keeps DRAIN alive.
    always_comb begin
        pend_after = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pend_after = pend_after | pipe_vld_q[i];
        end
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StPgRst;
            StPgRst: state_d = StRun;
            StRun:   if (pg_done) state_d = StDrain;
            StDrain: if (!pend_after) state_d = StDone;
            StDone:  if (start) state_d = StPgRst;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register; pg_rst is registered so it is high through reset
    // and for exactly the PGRST cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= StIdle;
            pg_rst_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pg_rst_q <= (state_d == StPgRst);
        end
    end

    // SRAM port registers; address/data hold while nothing is issued.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
            sram_wmask_q <= '0;
        end else begin
            sram_ce_q <= issue && (pg_we || pg_re);
            sram_we_q <= issue && pg_we;
            if (issue) begin
                sram_addr_q  <= pg_addr;
                sram_din_q   <= pg_data;
                sram_wmask_q <= pg_wmask;
            end
        end
    end

    // Check pipeline shift register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_addr_q[i] <= '0;
                pipe_chk_q[i]  <= '0;
            end
        end else if (state_q == StPgRst) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0]  <= push;
            pipe_addr_q[0] <= pg_addr;
            pipe_chk_q[0]  <= pg_check;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_chk_q[i]  <= pipe_chk_q[i-1];
            end
        end
    end

    // Result registers: cleared in PGRST, updated on mismatches and protocol errors.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            proto_err_q     <= 1'b0;
            err_count_q     <= '0;
            fail_seen_q     <= 1'b0;
            fail_addr_q     <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
        end else if (state_q == StPgRst) begin
            proto_err_q     <= 1'b0;
            err_count_q     <= '0;
            fail_seen_q     <= 1'b0;
            fail_addr_q     <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
        end else begin
            if (issue && pg_we && pg_re) begin
                proto_err_q <= 1'b1;
            end
            if (mismatch) begin
                if (err_count_q != {ERR_WIDTH{1'b1}}) begin
                    err_count_q <= err_count_q + 1'b1;
                end
                if (!fail_seen_q) begin
                    fail_seen_q     <= 1'b1;
                    fail_addr_q     <= pipe_addr_q[READ_LATENCY-1];
                    fail_expected_q <= pipe_chk_q[READ_LATENCY-1];
                    fail_actual_q   <= sram_dout;
                end
            end
        end
    end

    // Status and output mapping.
    always_comb begin
        pg_en         = issue;
        pg_rst        = pg_rst_q;
        busy          = (state_q == StPgRst) || (state_q == StRun) || (state_q == StDrain);
        done          = (state_q == StDone);
        pass          = done && (err_count_q == '0) && !proto_err_q;
        sram_ce       = sram_ce_q;
        sram_we       = sram_we_q;
        sram_addr     = sram_addr_q;
        sram_din      = sram_din_q;
        sram_wmask    = sram_wmask_q;
        proto_err     = proto_err_q;
        err_count     = err_count_q;
        fail_addr     = fail_addr_q;
        fail_expected = fail_expected_q;
        fail_actual   = fail_actual_q;
    end

endmodule

// File: tb/tb_det_patgen_runner.sv
// Bench for det_patgen_runner: two instances (latency 1 / 8-bit count and
// latency 2 / 2-bit count) share one bench-driven generator; each has its own
// SRAM model with a per-address read corruption mask.
module tb_det_patgen_runner;

    logic        clk;
    logic        rstb;
    logic        start;
    logic [4:0]  pg_addr;
    logic [31:0] pg_data;
    logic [31:0] pg_check;
    logic [3:0]  pg_wmask;
    logic        pg_we, pg_re, pg_done;

    logic        pg_en1, pg_rst1, ce1, we1, busy1, done1, pass1, proto1;
    logic [4:0]  addr1, faddr1;
    logic [31:0] din1, dout1, fexp1, fact1;
    logic [3:0]  wmask1;
    logic [7:0]  err1;

    logic        pg_en2, pg_rst2, ce2, we2, busy2, done2, pass2, proto2;
    logic [4:0]  addr2, faddr2;
    logic [31:0] din2, dout2, fexp2, fact2;
    logic [3:0]  wmask2;
    logic [1:0]  err2;

    logic [31:0] mem1 [32];
    logic [31:0] mem2 [32];
    logic [31:0] flip [32];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [3:0]  wmask;
    } iss_t;
    iss_t sbq[$];

    typedef struct {
        int          nw;
        int          nr;
        int          c_addr;
        int          c_cnt;
        logic [31:0] c_mask;
        int          proto_idx;
        int          e_err1;
        int          e_err2;
        int          e_faddr;
        logic [31:0] e_fexp;
        logic [31:0] e_fact;
        logic        e_proto;
        logic        e_pass;
    } vec_t;
    vec_t vecs[8];

    det_patgen_runner #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .MASK_WIDTH(4), .READ_LATENCY(1), .ERR_WIDTH(8)
    ) dut1 (
        .clk(clk), .rstb(rstb), .start(start), .pg_en(pg_en1), .pg_rst(pg_rst1),
        .pg_addr(pg_addr), .pg_data(pg_data), .pg_check(pg_check), .pg_wmask(pg_wmask),
        .pg_we(pg_we), .pg_re(pg_re), .pg_done(pg_done),
        .sram_ce(ce1), .sram_we(we1), .sram_addr(addr1), .sram_din(din1),
        .sram_wmask(wmask1), .sram_dout(dout1), .busy(busy1), .done(done1), .pass(pass1),
        .proto_err(proto1), .err_count(err1), .fail_addr(faddr1),
        .fail_expected(fexp1), .fail_actual(fact1)
    );

    det_patgen_runner #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .MASK_WIDTH(4), .READ_LATENCY(2), .ERR_WIDTH(2)
    ) dut2 (
        .clk(clk), .rstb(rstb), .start(start), .pg_en(pg_en2), .pg_rst(pg_rst2),
        .pg_addr(pg_addr), .pg_data(pg_data), .pg_check(pg_check), .pg_wmask(pg_wmask),
        .pg_we(pg_we), .pg_re(pg_re), .pg_done(pg_done),
        .sram_ce(ce2), .sram_we(we2), .sram_addr(addr2), .sram_din(din2),
        .sram_wmask(wmask2), .sram_dout(dout2), .busy(busy2), .done(done2), .pass(pass2),
        .proto_err(proto2), .err_count(err2), .fail_addr(faddr2),
        .fail_expected(fexp2), .fail_actual(fact2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 SRAM: synchronous masked write, asynchronous read.
    always @(posedge clk) begin
        if (ce1 && we1) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask1[b]) mem1[addr1][b*8 +: 8] <= din1[b*8 +: 8];
            end
        end
    end
    assign dout1 = mem1[addr1] ^ flip[addr1];

    // Latency-2 SRAM: synchronous masked write, registered read.
    always @(posedge clk) begin
        if (ce2 && we2) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask2[b]) mem2[addr2][b*8 +: 8] <= din2[b*8 +: 8];
            end
        end
        if (ce2 && !we2) dout2 <= mem2[addr2] ^ flip[addr2];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Pops the op expected to appear on the SRAM port one cycle after it was driven.
    task automatic sb_check();
        iss_t e;
        if (ce1) begin
            if (sbq.size() != 1) begin
                total++;
                bad++;
                $display("FAIL issue_timing: queued=%0d want 1", sbq.size());
                sbq.delete();
            end else begin
                e = sbq.pop_front();
                chk("sram_we", we1, e.we);
                chk("sram_addr", addr1, e.addr);
                chk("sram_din", din1, e.din);
                chk("sram_wmask", wmask1, e.wmask);
                chk("sram_ce2", ce2, 1);
                chk("sram_addr2", addr2, e.addr);
            end
        end else if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL issue_missing: sram_ce=0 with %0d op(s) queued", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic step(input logic we, input logic re, input logic [4:0] a,
                        input logic [31:0] d, input logic dn);
        iss_t e;
        @(negedge clk);
        sb_check();
        pg_we    = we;
        pg_re    = re;
        pg_addr  = a;
        pg_data  = d;
        pg_check = d;
        pg_wmask = 4'hF;
        pg_done  = dn;
        if (!dn && (we || re)) begin
            e.we    = we;
            e.addr  = a;
            e.din   = d;
            e.wmask = 4'hF;
            sbq.push_back(e);
        end
        #1;
        chk("pg_en", pg_en1, {31'b0, !dn});
    endtask

    task automatic start_run();
        @(negedge clk);
        sb_check();
        start   = 1'b1;
        pg_done = 1'b0;
        pg_we   = 1'b0;
        pg_re   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("pgrst_pg_rst", pg_rst1, 1);
        chk("pgrst_busy", busy1, 1);
        chk("pgrst_pg_en", pg_en1, 0);
        chk("pgrst_done", done1, 0);
    endtask

    task automatic finish_run();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (done1 && done2) break;
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        end
        if (!(done1 && done2)) begin
            total++;
            bad++;
            $display("FAIL done_timeout: done1=%0b done2=%0b want 1 1", done1, done2);
        end
    endtask

    task automatic run_vec(input vec_t v);
        for (int a = 0; a < 32; a++) flip[a] = 32'd0;
        for (int k = 0; k < v.c_cnt; k++) flip[v.c_addr + k] = v.c_mask;
        start_run();
        for (int i = 0; i < v.nw; i++) begin
            step(1'b1, (i == v.proto_idx), 5'(i), 32'(i), 1'b0);
            if (i == 0) chk("pg_rst_one_cycle", pg_rst1, 0);
            if (i == 4) begin
                chk("start_busy_no_restart", pg_rst1, 0);
                chk("start_busy_still_busy", busy1, 1);
            end
            start = (i == 3);
        end
        start = 1'b0;
        for (int i = 0; i < v.nr; i++) step(1'b0, 1'b1, 5'(i), 32'(i), 1'b0);
        finish_run();
        chk("res_busy", busy1, 0);
        chk("res_pass1", pass1, v.e_pass);
        chk("res_pass2", pass2, v.e_pass);
        chk("res_proto", proto1, v.e_proto);
        chk("res_err1", err1, v.e_err1);
        chk("res_err2", err2, v.e_err2);
        chk("res_faddr", faddr1, v.e_faddr);
        chk("res_fexp", fexp1, v.e_fexp);
        chk("res_fact", fact1, v.e_fact);
        chk("res_faddr2", faddr2, v.e_faddr);
    endtask

    initial begin
        vecs[0] = '{16, 16,  0,  0, 32'h0,         -1,  0, 0,  0, 32'h0,  32'h0,         1'b0, 1'b1};
        vecs[1] = '{16, 16,  5,  1, 32'h8,         -1,  1, 1,  5, 32'h5,  32'hD,         1'b0, 1'b0};
        vecs[2] = '{16, 16,  3,  5, 32'h100,       -1,  5, 3,  3, 32'h3,  32'h103,       1'b0, 1'b0};
        vecs[3] = '{16, 16,  0,  0, 32'h0,         -1,  0, 0,  0, 32'h0,  32'h0,         1'b0, 1'b1};
        vecs[4] = '{ 8,  8,  0,  0, 32'h0,          2,  0, 0,  0, 32'h0,  32'h0,         1'b1, 1'b0};
        vecs[5] = '{32, 32, 31,  1, 32'h8000_0000, -1,  1, 1, 31, 32'h1F, 32'h8000_001F, 1'b0, 1'b0};
        vecs[6] = '{ 4,  4,  0,  1, 32'hFFFF_FFFF, -1,  1, 1,  0, 32'h0,  32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{32, 32,  0, 32, 32'h1,         -1, 32, 3,  0, 32'h0,  32'h1,         1'b0, 1'b0};

        for (int a = 0; a < 32; a++) flip[a] = 32'd0;
        rstb = 1'b1; start = 1'b0;
        pg_we = 1'b0; pg_re = 1'b0; pg_done = 1'b0;
        pg_addr = '0; pg_data = '0; pg_check = '0; pg_wmask = '0;
        #1 rstb = 1'b0;
        #2;
        chk("rst_pg_rst", pg_rst1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_sram_ce", ce1, 0);
        chk("rst_err", err1, 0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("idle_pg_rst", pg_rst1, 0);
        chk("idle_pass", pass1, 0);

        foreach (vecs[n]) run_vec(vecs[n]);

        // Last op a read right before pg_done: checked during DRAIN on the latency-2 unit.
        for (int a = 0; a < 32; a++) flip[a] = 32'd0;
        flip[9] = 32'h1;
        start_run();
        step(1'b1, 1'b0, 5'd9, 32'd9, 1'b0);
        step(1'b0, 1'b1, 5'd9, 32'd9, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk("drain_done2_early", done2, 0);
        chk("drain_busy2", busy2, 1);
        @(negedge clk);
        chk("drain_done2", done2, 1);
        chk("drain_err2", err2, 1);
        chk("drain_faddr2", faddr2, 9);
        chk("drain_fexp2", fexp2, 9);
        chk("drain_fact2", fact2, 8);
        chk("drain_pass2", pass2, 0);
        chk("drain_err1", err1, 1);

        // Asynchronous reset in the middle of the read phase.
        for (int a = 0; a < 32; a++) flip[a] = 32'd0;
        flip[1] = 32'h10;
        start_run();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'(i), 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5'(i), 32'(i), 1'b0);
        chk("pre_reset_err", err1, 1);
        #2 rstb = 1'b0;
        #1;
        chk("midrst_pg_rst", pg_rst1, 1);
        chk("midrst_busy", busy1, 0);
        chk("midrst_done", done1, 0);
        chk("midrst_pass", pass1, 0);
        chk("midrst_sram_ce", ce1, 0);
        chk("midrst_err", err1, 0);
        chk("midrst_fail_addr", faddr1, 0);
        chk("midrst_busy2", busy2, 0);
        pg_we = 1'b0; pg_re = 1'b0; pg_done = 1'b0;
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk("postrst_done", done1, 0);
        chk("postrst_err", err1, 0);

        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
